// File: rtl/traffic_phase_fsm.sv
// Two-road traffic phase sequencer driven by an external countdown; reloads the countdown at each phase change.
// Optional pedestrian walk phase is enabled with `define PED_REQUEST_EN.
module traffic_phase_fsm #(
    parameter int T_GREEN  = 9,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int T_WALK   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] count,
`ifdef PED_REQUEST_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic       load,
    output logic [3:0] load_value,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] phase
);

    // state     | meaning
    // NS_GREEN  | north-south green, east-west red
    // NS_YELLOW | north-south yellow, east-west red
    // RED_A     | all-red clearance before east-west
    // EW_GREEN  | east-west green, north-south red
    // EW_YELLOW | east-west yellow, north-south red
    // RED_B     | all-red clearance before north-south (reset state)
    // PED_WALK  | all-red with walk lamp (PED_REQUEST_EN only)
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5
`ifdef PED_REQUEST_EN
        , PED_WALK = 3'd6
`endif
    } state_t;

    if (T_GREEN < 1 || T_GREEN > 15 || T_YELLOW < 1 || T_YELLOW > 15 ||
        T_ALLRED < 1 || T_ALLRED > 15 || T_WALK < 1 || T_WALK > 15) begin : g_param_check
        $error("traffic_phase_fsm: phase durations must be in 1..15");
    end

    state_t     state;
    state_t     state_next;
    logic       load_next;
    logic [3:0] load_value_next;
    logic       advance;
`ifdef PED_REQUEST_EN
    logic       ped_flag;
    logic       ped_flag_next;
`endif

    function automatic logic [3:0] duration(input state_t s);
        logic [3:0] d;
        case (s)
            NS_GREEN,  EW_GREEN:  d = 4'(T_GREEN);
            NS_YELLOW, EW_YELLOW: d = 4'(T_YELLOW);
`ifdef PED_REQUEST_EN
            PED_WALK:             d = 4'(T_WALK);
`endif
            default:              d = 4'(T_ALLRED);
        endcase
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RED_B;
            load       <= 1'b1;
            load_value <= 4'(T_ALLRED);
`ifdef PED_REQUEST_EN
            ped_flag   <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            load       <= load_next;
            load_value <= load_value_next;
`ifdef PED_REQUEST_EN
            ped_flag   <= ped_flag_next;
`endif
        end
    end

    // The count just after a load is stale, so a tick in a load cycle is ignored.
    assign advance = tick && (count == 4'd0) && !load;

    always_comb begin
        state_next      = state;
        load_next       = 1'b0;
        load_value_next = load_value;
`ifdef PED_REQUEST_EN
        ped_flag_next   = ped_flag | ped_req;
`endif
        case (state)
            NS_GREEN:  if (advance) state_next = NS_YELLOW;
            NS_YELLOW: if (advance) state_next = RED_A;
            RED_A:     if (advance) state_next = EW_GREEN;
            EW_GREEN:  if (advance) state_next = EW_YELLOW;
            EW_YELLOW: if (advance) state_next = RED_B;
            RED_B: begin
                if (advance) begin
`ifdef PED_REQUEST_EN
                    if (ped_flag_next) begin
                        state_next    = PED_WALK;
                        ped_flag_next = 1'b0;
                    end else begin
                        state_next = NS_GREEN;
                    end
`else
                    state_next = NS_GREEN;
`endif
                end
            end
`ifdef PED_REQUEST_EN
            PED_WALK:  if (advance) state_next = NS_GREEN;
`endif
            default:   state_next = RED_B;
        endcase
        if (state_next != state) begin
            load_next       = 1'b1;
            load_value_next = duration(state_next);
        end
    end

    always_comb begin
        ns_light = 3'b100;
        ew_light = 3'b100;
        case (state)
            NS_GREEN:  ns_light = 3'b001;
            NS_YELLOW: ns_light = 3'b010;
            EW_GREEN:  ew_light = 3'b001;
            EW_YELLOW: ew_light = 3'b010;
            default: begin
                ns_light = 3'b100;
                ew_light = 3'b100;
            end
        endcase
    end

    assign phase = state;
`ifdef PED_REQUEST_EN
    assign walk = (state == PED_WALK);
`endif

endmodule

// File: doc/traffic_phase_fsm.md
Name: traffic_phase_fsm

Overview:
- Downstream consumer of the 4-bit phase countdown (decrementer) in the traffic signal design.
- Watches the countdown value and sequences a two-road intersection through green/yellow/all-red phases.
- At each phase change, issues a one-cycle load pulse with the new phase duration back to the decrementer.
- Drives the north-south (NS) and east-west (EW) lamp outputs and a phase code for the 7-segment display logic.

Parameters:
- T_GREEN, 9, green phase duration in ticks (1..15)
- T_YELLOW, 3, yellow phase duration in ticks (1..15)
- T_ALLRED, 1, all-red clearance duration in ticks (1..15)
- T_WALK, 5, pedestrian walk duration in ticks (1..15); used only with PED_REQUEST_EN

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- tick  in  1  one-cycle enable from the clock divider, marks one countdown step
- count  in  4  current countdown value from the decrementer
- load  out  1  registered one-cycle pulse; decrementer loads load_value
- load_value  out  4  registered duration of the phase just entered
- ns_light  out  3  {red,yellow,green}, one-hot
- ew_light  out  3  {red,yellow,green}, one-hot
- phase  out  3  encoded current state for display/debug

Behaviour:
- Decided: one clock (clk); rst synchronous, active-high.
- States and encodings, in cycle order:
  - NS_GREEN=0
  - NS_YELLOW=1
  - RED_A=2
  - EW_GREEN=3
  - EW_YELLOW=4
  - RED_B=5
  - RED_B then returns to NS_GREEN.
- Reset values:
  - state=RED_B, phase=5
  - ns_light=3'b100, ew_light=3'b100
  - load=1, load_value=T_ALLRED (decrementer preloads the clearance time)
- Advance condition: tick=1 AND count==0 AND load==0.
  - count is treated as stale in any cycle where load=1.
- On advance at edge N:
  - state, phase and lights update at edge N.
  - load=1 for exactly one cycle (N to N+1), load_value = duration of the new state.
  - Latency from qualifying tick to new lights: 1 clock.
- load_value holds its last value when load=0.
- Lamp map:
  - NS_GREEN: ns=001, ew=100
  - NS_YELLOW: ns=010, ew=100
  - RED_A and RED_B: both 100
  - EW_GREEN: ns=100, ew=001
  - EW_YELLOW: ns=100, ew=010
- Safety invariant: never both roads non-red in the same cycle.
- Illegal or unused state encodings recover to RED_B with load=1, load_value=T_ALLRED on the next edge.
- tick with count!=0: no action; counting is the decrementer's job.
- count==0 without tick: no action.
- tick coinciding with load=1: ignored.
- rst mid-phase: outputs take reset values on the next edge regardless of tick or count; rst has priority over everything.

Optional Feature:
- Macro: PED_REQUEST_EN
- Defined:
  - Adds ports ped_req (in, 1) and walk (out, 1, reset 0).
  - Adds state PED_WALK=6: both roads red, walk=1.
  - ped_req is latched into a sticky request flag in any cycle.
  - On advance out of RED_B with the flag set: enter PED_WALK (load_value=T_WALK) instead of NS_GREEN, and clear the flag.
  - PED_WALK advances to NS_GREEN.
  - ped_req arriving during PED_WALK re-latches and is served next cycle round.
  - rst clears the flag.
- Undefined: no ped_req or walk ports, state 6 is illegal (recovers to RED_B), and behaviour is exactly as above.

Test Plan:
- Reset: hold rst 3 cycles, release -> load=1, load_value=1, ns=ew=100, phase=5; load=0 on cycle after release.
- Full cycle: model decrementer, tick every 4 clks -> phases 0,1,2,3,4,5,0; load_value sequence 9,3,1,9,3,1; each load pulse exactly 1 clk wide.
- Guards:
  - count=0 with tick=0 for 20 clks -> no state change.
  - tick in the same cycle as load=1 with count=0 -> no advance.
- Reset mid-phase: rst asserted in EW_GREEN with count=5 -> next edge phase=5, both red, load=1, load_value=1.
- Safety: random tick/count stimulus over 10k cycles -> assertion that ns_light and ew_light are never both non-100.
- PED_REQUEST_EN: pulse ped_req during NS_GREEN -> after RED_B enter phase 6, walk=1, load_value=5, then NS_GREEN with walk=0; with no request, RED_B goes directly to NS_GREEN.
